// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem request tracking
// and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic        Jump,
  input  logic [31:0] PCBranchD,
  input  logic [27:0] PCJ,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  logic [1:0]  state;
  logic [31:0] pcf;
  logic [31:0] dropaddr;
  logic [31:0] bufinstr;
  logic [31:0] bufpc4;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcplus4;
  logic        avail;
  logic [31:0] word;
  logic [31:0] wordpc4;

  assign redirect = (Jump | PCSrcD) & ~StallD;
  assign target   = Jump ? {PCPlus4D[31:28], PCJ} : PCBranchD;
  assign pcplus4  = pcf + 32'd4;

  // A word is available either fresh from memory or from the buffer.
  assign avail   = (state == HOLD) | ((state == FETCH) & ImemAck);
  assign word    = (state == HOLD) ? bufinstr : ImemRdata;
  assign wordpc4 = (state == HOLD) ? bufpc4 : pcplus4;

  // The dropped request keeps its original address until acked.
  assign ImemReq  = (state != HOLD);
  assign ImemAddr = (state == DROP) ? dropaddr : pcf;

  // PC, request state and stall buffer.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      pcf      <= RESET_PC;
      dropaddr <= RESET_PC;
      bufinstr <= 32'd0;
      bufpc4   <= 32'd0;
    end else begin
      unique case (1'b1)
        (state == FETCH): begin
          if (redirect) begin
            pcf <= target;
            if (!ImemAck) begin
              state    <= DROP;
              dropaddr <= pcf;
            end
          end else if (ImemAck) begin
            if (StallF) begin
              state    <= HOLD;
              bufinstr <= ImemRdata;
              bufpc4   <= pcplus4;
            end else begin
              pcf <= pcplus4;
            end
          end
        end
        (state == HOLD): begin
          if (redirect) begin
            pcf      <= target;
            state    <= FETCH;
            bufinstr <= 32'd0;
          end else if (!StallF) begin
            pcf   <= bufpc4;
            state <= FETCH;
          end
        end
        (state == DROP): begin
          if (redirect) pcf <= target;
          if (ImemAck) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

  // IF/ID register: load a word, else insert a bubble, unless stalled.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      InstrD   <= 32'd0;
      PCPlus4D <= 32'd0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      if (!redirect && avail && !StallF) begin
        InstrD   <= word;
        PCPlus4D <= wordpc4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= 32'd0;
        ValidD <= 1'b0;
      end
    end
  end

endmodule
